vram_fetch_sched: RTL and testbench
===================================

Name: vram_fetch_sched

Overview:
- Time-slot scheduler for the single-port video RAM (VRAM) feeding the 800x600 text display.
- Per 8-pixel character cell, it sequences a text-word read and a font-row read, then hands the remaining slots to a host read/write port.
- Fetched char/attr/font bits go to the pixel output stage, which is driven by the timing generator's line/frame events.

Parameters:
COLS, 100, character cells per line (800/8)
FONT_H, 16, font rows per character
CELL_CLKS, 8, clocks per cell slot cycle (legal 4..16)
TEXT_BASE, 16'h0000, VRAM word address of text buffer (char in [7:0], attr in [15:8])
FONT_BASE, 16'h8000, VRAM word address of font (pixel bits in [7:0], MSB = leftmost)

Ports:
clk  in  1  40 MHz pixel clock
nrst  in  1  asynchronous active-low reset
frame_start  in  1  one-clock pulse: first fetch line of frame
line_start  in  1  one-clock pulse: begin fetching cells for one visible line
host_req  in  1  host request; addr/we/wdata held stable until host_ack
host_we  in  1  1 = write, 0 = read
host_addr  in  16  host word address
host_wdata  in  16  host write data
host_ack  out  1  one-clock pulse: request complete
host_rdata  out  16  read data, valid while host_ack = 1
vram_addr  out  16  VRAM address
vram_we  out  1  VRAM write enable
vram_wdata  out  16  VRAM write data
vram_rdata  in  16  VRAM read data, available 1 clock after address
cell_valid  out  1  one-clock pulse: cell outputs updated
cell_char  out  8  character code
cell_attr  out  8  attribute byte
cell_bits  out  8  font row pixels

Behaviour:
- Reset (async, nrst = 0): all outputs 0; state IDLE; slot, col, font_row, row_base cleared.
- States: IDLE (no fetch, every cycle a host slot), FETCH (cells in progress).
- line_start: IDLE/FETCH -> FETCH with col = 0, slot = 0. A line_start during FETCH aborts the current line and restarts. No cell_valid is issued for the aborted cell.
- Slot counter runs 0..CELL_CLKS-1 in FETCH.
  - Slot 0: vram_addr = TEXT_BASE + row_base + col, we = 0.
  - Slot 1: vram_addr = FONT_BASE + vram_rdata[7:0]*FONT_H + font_row, computed combinationally from vram_rdata. Text word latched.
  - Slot 2: font data latched. cell_char/attr/bits and cell_valid = 1 are registered, so they are visible in slot 3.
  - Slots 2..CELL_CLKS-1: host slots.
- On the last slot of a cell: col++.
- On the last slot of cell col = COLS-1: -> IDLE, and font_row++.
  - If font_row was FONT_H-1: font_row = 0 and row_base += COLS.
- frame_start: row_base = 0, font_row = 0, fetch aborted -> IDLE. If line_start arrives in the same cycle, the frame reset applies first, then FETCH starts with row 0.
- Host grant: in a host slot with host_req = 1 and no ack pending, drive vram_addr/we/wdata from the host in that cycle (cycle N).
  - host_ack = 1 in N+1; host_rdata = vram_rdata captured in N+1.
  - No grant in N+1; the next request can be granted at N+2 at the earliest.
  - Writes ack identically, with host_rdata undefined.
- When neither display nor host owns the cycle: vram_we = 0, vram_addr holds its last value.
- Display slots 0/1 are never yielded. Host latency is bounded by 3 clocks (CELL_CLKS = 8).
- Arithmetic: all addresses 16-bit, wrap modulo 2^16. row_base wraps silently.

Optional Feature:
CURSOR_EN:
- Adds inputs cursor_col[7:0] and cursor_row[7:0], and output cell_cursor (1 bit, reset 0).
- cell_cursor is registered with cell_valid. It is 1 when col == cursor_col and the text row (row_base/COLS, tracked as a separate counter) == cursor_row.
- Without the macro: ports absent, no extra logic.

Test Plan:
- Reset mid-FETCH (nrst low at slot 1, col 5) -> all outputs 0 immediately; after release, no cell_valid until line_start.
- frame_start, line_start, VRAM[0x0000] = 16'h1E41, VRAM[0x8000+0x41*16] = 16'h00F0 -> cell_valid at slot 3 of cell 0 with char 0x41, attr 0x1E, bits 0xF0; exactly 100 cell_valid pulses; then IDLE.
- 16 lines after frame_start -> line 16 reads text at 0x0064 (row_base = 100), font_row = 0; line 15 used font_row = 15.
- host_req write 0x1234 to 0x0050 asserted at slot 0 -> granted at slot 2, host_ack at slot 3; a read of 0x0050 -> host_rdata = 0x1234.
- host_req held through 3 back-to-back reads in IDLE -> grants on alternate cycles, 3 ack pulses, no conflict with a line_start arriving mid-sequence (display wins slot 0).
- line_start during col 40 -> restart at col 0; frame_start + line_start in the same cycle -> text address 0x0000, font_row 0.

Source files
------------

// File: rtl/vram_fetch_sched.sv
// VRAM slot scheduler: text-word and font-row fetch per character cell, spare slots go to the host port.
// Optional CURSOR_EN build adds cursor_col/cursor_row inputs and a registered cell_cursor output.
module vram_fetch_sched #(
  parameter int          COLS      = 100,
  parameter int          FONT_H    = 16,
  parameter int          CELL_CLKS = 8,
  parameter logic [15:0] TEXT_BASE = 16'h0000,
  parameter logic [15:0] FONT_BASE = 16'h8000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        frame_start,
  input  logic        line_start,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic [15:0] vram_addr,
  output logic        vram_we,
  output logic [15:0] vram_wdata,
  input  logic [15:0] vram_rdata,
  output logic        cell_valid,
  output logic [7:0]  cell_char,
  output logic [7:0]  cell_attr,
`ifdef CURSOR_EN
  input  logic [7:0]  cursor_col,
  input  logic [7:0]  cursor_row,
  output logic        cell_cursor,
`endif
  output logic [7:0]  cell_bits
);

  localparam int              FR_W      = (FONT_H > 1) ? $clog2(FONT_H) : 1;
  localparam logic [3:0]      LAST_SLOT = 4'(CELL_CLKS - 1);
  localparam logic [7:0]      LAST_COL  = 8'(COLS - 1);
  localparam logic [FR_W-1:0] LAST_FROW = FR_W'(FONT_H - 1);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        slot_reg, slot_next;
  logic [7:0]        col_reg, col_next;
  logic [FR_W-1:0]   font_row_reg, font_row_next;
  logic [15:0]       row_base_reg, row_base_next;
  logic [15:0]       text_reg;
  logic [15:0]       last_addr_reg;
  logic              ack_reg;
  logic              cell_valid_reg;
  logic [7:0]        cell_char_reg, cell_attr_reg, cell_bits_reg;
  logic              cell_load, text_load, host_slot, grant;
  logic [15:0]       text_addr, font_addr;

  always_comb begin
    state_next    = state_reg;
    slot_next     = slot_reg;
    col_next      = col_reg;
    font_row_next = font_row_reg;
    row_base_next = row_base_reg;
    cell_load     = 1'b0;
    text_load     = 1'b0;
    // Frame reset is applied first so a coincident line_start fetches row 0.
    if (frame_start) begin
      state_next    = IDLE;
      slot_next     = 4'd0;
      col_next      = 8'd0;
      font_row_next = '0;
      row_base_next = 16'd0;
    end
    if (line_start) begin
      state_next = FETCH;
      slot_next  = 4'd0;
      col_next   = 8'd0;
    end else if (!frame_start && state_reg == FETCH) begin
      text_load = (slot_reg == 4'd1);
      cell_load = (slot_reg == 4'd2);
      if (slot_reg == LAST_SLOT) begin
        slot_next = 4'd0;
        col_next  = col_reg + 8'd1;
        if (col_reg == LAST_COL) begin
          state_next = IDLE;
          col_next   = 8'd0;
          if (font_row_reg == LAST_FROW) begin
            font_row_next = '0;
            row_base_next = row_base_reg + 16'(COLS);
          end else begin
            font_row_next = font_row_reg + FR_W'(1);
          end
        end
      end else begin
        slot_next = slot_reg + 4'd1;
      end
    end
  end

  assign text_addr = TEXT_BASE + row_base_reg + {8'h00, col_reg};
  assign font_addr = FONT_BASE + {8'h00, vram_rdata[7:0]} * 16'(FONT_H) + 16'(font_row_reg);
  assign host_slot = (state_reg == IDLE) || (slot_reg >= 4'd2);
  assign grant     = host_slot && host_req && !ack_reg;

  always_comb begin
    vram_addr  = last_addr_reg;
    vram_we    = 1'b0;
    vram_wdata = 16'd0;
    if (state_reg == FETCH && slot_reg == 4'd0) begin
      vram_addr = text_addr;
    end else if (state_reg == FETCH && slot_reg == 4'd1) begin
      vram_addr = font_addr;
    end else if (grant) begin
      vram_addr  = host_addr;
      vram_we    = host_we;
      vram_wdata = host_wdata;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg      <= IDLE;
      slot_reg       <= 4'd0;
      col_reg        <= 8'd0;
      font_row_reg   <= '0;
      row_base_reg   <= 16'd0;
      text_reg       <= 16'd0;
      last_addr_reg  <= 16'd0;
      ack_reg        <= 1'b0;
      cell_valid_reg <= 1'b0;
      cell_char_reg  <= 8'd0;
      cell_attr_reg  <= 8'd0;
      cell_bits_reg  <= 8'd0;
    end else begin
      state_reg      <= state_next;
      slot_reg       <= slot_next;
      col_reg        <= col_next;
      font_row_reg   <= font_row_next;
      row_base_reg   <= row_base_next;
      last_addr_reg  <= vram_addr;
      ack_reg        <= grant;
      cell_valid_reg <= cell_load;
      if (text_load) text_reg <= vram_rdata;
      if (cell_load) begin
        cell_char_reg <= text_reg[7:0];
        cell_attr_reg <= text_reg[15:8];
        cell_bits_reg <= vram_rdata[7:0];
      end
    end
  end

`ifdef CURSOR_EN
  logic [7:0] text_row_reg;
  logic       cell_cursor_reg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      text_row_reg    <= 8'd0;
      cell_cursor_reg <= 1'b0;
    end else begin
      if (frame_start)
        text_row_reg <= 8'd0;
      else if (row_base_next != row_base_reg)
        text_row_reg <= text_row_reg + 8'd1;
      if (cell_load)
        cell_cursor_reg <= (col_reg == cursor_col) && (text_row_reg == cursor_row);
    end
  end

  assign cell_cursor = cell_cursor_reg;
`endif

  // Read data is only meaningful in the ack cycle, so it is gated rather than stored.
  assign host_rdata = ack_reg ? vram_rdata : 16'd0;
  assign host_ack   = ack_reg;
  assign cell_valid = cell_valid_reg;
  assign cell_char  = cell_char_reg;
  assign cell_attr  = cell_attr_reg;
  assign cell_bits  = cell_bits_reg;

endmodule

// File: tb/tb_vram_fetch_sched.sv
// Directed bench for vram_fetch_sched with a behavioural single-port VRAM (1-clock read latency).
`timescale 1ns/1ps
module tb_vram_fetch_sched;

  logic        clk = 1'b0;
  logic        nrst;
  logic        frame_start, line_start;
  logic        host_req, host_we;
  logic [15:0] host_addr, host_wdata;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic [15:0] vram_addr;
  logic        vram_we;
  logic [15:0] vram_wdata;
  logic [15:0] vram_rdata;
  logic        cell_valid;
  logic [7:0]  cell_char, cell_attr, cell_bits;

  logic [15:0] mem [0:65535];

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] ln_a0, ln_a1;
  logic [23:0] ln_cell;
  int          ln_n, ln_first;

  always #12.5 clk = ~clk;

  vram_fetch_sched dut (
    .clk         (clk),
    .nrst        (nrst),
    .frame_start (frame_start),
    .line_start  (line_start),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_ack    (host_ack),
    .host_rdata  (host_rdata),
    .vram_addr   (vram_addr),
    .vram_we     (vram_we),
    .vram_wdata  (vram_wdata),
    .vram_rdata  (vram_rdata),
    .cell_valid  (cell_valid),
    .cell_char   (cell_char),
    .cell_attr   (cell_attr),
    .cell_bits   (cell_bits)
  );

  always @(posedge clk) begin
    vram_rdata <= mem[vram_addr];
    if (vram_we) mem[vram_addr] = vram_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("  ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Called right after a rising edge; returns right after a rising edge with the line finished.
  task automatic fetch_line(input logic fs);
    frame_start = fs;
    line_start  = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    line_start  = 1'b0;
    ln_n = 0;
    ln_first = -1;
    ln_cell = 24'd0;
    for (int i = 0; i < 810; i++) begin
      @(negedge clk);
      if (i == 0) ln_a0 = vram_addr;
      if (i == 1) ln_a1 = vram_addr;
      if (cell_valid) begin
        if (ln_n == 0) begin
          ln_first = i;
          ln_cell  = {cell_char, cell_attr, cell_bits};
        end
        ln_n++;
      end
      @(posedge clk); #1;
    end
    $display("  line fs=%0d a0=0x%04h a1=0x%04h valids=%0d first@%0d cell=0x%06h",
             fs, ln_a0, ln_a1, ln_n, ln_first, ln_cell);
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acks, n1, n2;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'h1E41;
    mem[16'h8410] = 16'h00F0;
    mem[16'h0064] = 16'h0742;
    mem[16'h8420] = 16'h0081;

    nrst = 1'b0; frame_start = 1'b0; line_start = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 16'h0; host_wdata = 16'h0;

    repeat (3) step();
    @(negedge clk);
    check_eq("rst host_ack", 32'(host_ack), 0);
    check_eq("rst host_rdata", 32'(host_rdata), 0);
    check_eq("rst vram_addr", 32'(vram_addr), 0);
    check_eq("rst vram_we", 32'(vram_we), 0);
    check_eq("rst cell_valid", 32'(cell_valid), 0);
    check_eq("rst cell outputs", 32'({cell_char, cell_attr, cell_bits}), 0);
    step();
    nrst = 1'b1;
    step();

    // Line 0 of a frame, frame_start and line_start together.
    fetch_line(1'b1);
    check_eq("l0 text addr", 32'(ln_a0), 32'h0000);
    check_eq("l0 font addr", 32'(ln_a1), 32'h8410);
    check_eq("l0 first valid slot", ln_first, 3);
    check_eq("l0 cell char/attr/bits", 32'(ln_cell), 32'h411EF0);
    check_eq("l0 valid count", ln_n, 100);

    for (int l = 1; l < 15; l++) fetch_line(1'b0);
    fetch_line(1'b0);
    check_eq("l15 text addr", 32'(ln_a0), 32'h0000);
    check_eq("l15 font addr row15", 32'(ln_a1), 32'h841F);
    fetch_line(1'b0);
    check_eq("l16 text addr", 32'(ln_a0), 32'h0064);
    check_eq("l16 font addr row0", 32'(ln_a1), 32'h8420);
    check_eq("l16 cell", 32'(ln_cell), 32'h420781);
    check_eq("l16 valid count", ln_n, 100);

    // Host write then read during a fetch line (font_row 1).
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0050; host_wdata = 16'h1234;
    @(negedge clk);
    check_eq("hw slot0 display addr", 32'(vram_addr), 32'h0064);
    check_eq("hw slot0 we", 32'(vram_we), 0);
    step(); @(negedge clk);
    check_eq("hw slot1 font addr", 32'(vram_addr), 32'h8421);
    check_eq("hw slot1 no ack", 32'(host_ack), 0);
    step(); @(negedge clk);
    check_eq("hw slot2 grant addr", 32'(vram_addr), 32'h0050);
    check_eq("hw slot2 we", 32'(vram_we), 1);
    check_eq("hw slot2 wdata", 32'(vram_wdata), 32'h1234);
    step(); @(negedge clk);
    check_eq("hw slot3 ack", 32'(host_ack), 1);
    check_eq("hw slot3 we low", 32'(vram_we), 0);
    step();
    host_we = 1'b0;
    @(negedge clk);
    check_eq("hr slot4 grant addr", 32'(vram_addr), 32'h0050);
    check_eq("hr slot4 no ack", 32'(host_ack), 0);
    step(); @(negedge clk);
    check_eq("hr slot5 ack", 32'(host_ack), 1);
    check_eq("hr slot5 rdata", 32'(host_rdata), 32'h1234);
    step();
    host_req = 1'b0;
    repeat (800) step();

    // Back-to-back reads in IDLE, line_start arriving mid-sequence (font_row 2).
    acks = 0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0050;
    @(negedge clk);
    check_eq("b2b c0 grant addr", 32'(vram_addr), 32'h0050);
    acks += int'(host_ack);
    step(); @(negedge clk);
    check_eq("b2b c1 ack", 32'(host_ack), 1);
    check_eq("b2b c1 rdata", 32'(host_rdata), 32'h1234);
    check_eq("b2b c1 addr held", 32'(vram_addr), 32'h0050);
    acks += int'(host_ack);
    step();
    host_addr = 16'h8410; line_start = 1'b1;
    @(negedge clk);
    check_eq("b2b c2 grant addr", 32'(vram_addr), 32'h8410);
    acks += int'(host_ack);
    step();
    line_start = 1'b0;
    @(negedge clk);
    check_eq("b2b c3 display wins slot0", 32'(vram_addr), 32'h0064);
    check_eq("b2b c3 rdata", 32'(host_rdata), 32'h00F0);
    acks += int'(host_ack);
    step();
    host_addr = 16'h0000;
    @(negedge clk);
    check_eq("b2b c4 slot1 font addr", 32'(vram_addr), 32'h8422);
    acks += int'(host_ack);
    step(); @(negedge clk);
    check_eq("b2b c5 slot2 grant addr", 32'(vram_addr), 32'h0000);
    acks += int'(host_ack);
    step(); @(negedge clk);
    check_eq("b2b c6 rdata", 32'(host_rdata), 32'h1E41);
    acks += int'(host_ack);
    check_eq("b2b ack pulses", acks, 3);
    step();
    host_req = 1'b0;
    repeat (800) step();

    // Abort at col 40 slot 2 (font_row 3); the interrupted cell must not report.
    n1 = 0; n2 = 0;
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    for (int i = 0; i < 1135; i++) begin
      @(negedge clk);
      if (i == 320) check_eq("abort col40 text addr", 32'(vram_addr), 32'h008C);
      if (i == 323) check_eq("abort restart col0 addr", 32'(vram_addr), 32'h0064);
      if (cell_valid) begin
        n2++;
        if (i <= 323) n1++;
      end
      step();
      if (i == 321) line_start = 1'b1;
      if (i == 322) line_start = 1'b0;
    end
    $display("  abort line: valids before restart=%0d total=%0d", n1, n2);
    check_eq("abort valids before restart", n1, 40);
    check_eq("abort valids total", n2, 140);

    // Frame restart with row_base non-zero.
    fetch_line(1'b1);
    check_eq("fs+ls text addr", 32'(ln_a0), 32'h0000);
    check_eq("fs+ls font addr row0", 32'(ln_a1), 32'h8410);
    check_eq("fs+ls valid count", ln_n, 100);

    // Reset in the middle of col 5, slot 1 (font_row 1, char 0).
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    repeat (41) step();
    #5;
    check_eq("pre-reset slot1 font addr", 32'(vram_addr), 32'h8001);
    nrst = 1'b0;
    #1;
    check_eq("async rst vram_addr", 32'(vram_addr), 0);
    check_eq("async rst host_ack", 32'(host_ack), 0);
    check_eq("async rst cell_valid", 32'(cell_valid), 0);
    step(); step();
    nrst = 1'b1;
    n1 = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cell_valid) n1++;
      step();
    end
    $display("  post-reset idle: valids=%0d", n1);
    check_eq("post-reset no cell_valid", n1, 0);
    check_eq("post-reset vram_addr", 32'(vram_addr), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
